instruction_printer: RTL and testbench

INSTRUCTION_PRINTER -- requirements
Module: instruction_printer

---
 rtl/instruction_printer_if.sv | 21 ++
 rtl/instruction_printer.sv | 140 ++++++++++++++
 tb/tb_instruction_printer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_printer_if.sv
// instruction_printer_if: request fields and ASCII stream handshake of instruction_printer
interface instruction_printer_if;
  logic       start;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       busy_flag;
  logic       done_flag;
  logic       error_flag;
  modport master (
    output start, opcode, funct3, funct7, ascii_ready,
    input  ascii_out, ascii_valid, busy_flag, done_flag, error_flag
  );
  modport slave (
    input  start, opcode, funct3, funct7, ascii_ready,
    output ascii_out, ascii_valid, busy_flag, done_flag, error_flag
  );
endinterface

// File: rtl/instruction_printer.sv
// instruction_printer: streams the RV32I mnemonic of an opcode/funct3/funct7 triple as lowercase ASCII
module instruction_printer #(
  parameter logic [7:0] TERMINATOR = 8'h20
) (
  input logic clk_in,
  input logic rst_in,
  instruction_printer_if.slave io
);
  typedef enum logic [2:0] {IDLE, LOOKUP, EMIT, TERM, DONE, ERROR} state_t;
  state_t      state;
  logic [6:0]  op_q, f7_q;
  logic [2:0]  f3_q, len, idx, dec_len;
  logic [39:0] buffer, dec_str, dec_left;
  logic [7:0]  out_q;
  logic        valid_q, busy_q, done_q, error_q;
  // mnemonics are right-justified string literals; an all-zero result marks an illegal encoding
  always_comb begin
    dec_str = '0;
    case (op_q)
      7'b0110111: dec_str = 40'("lui");
      7'b0010111: dec_str = 40'("auipc");
      7'b1101111: dec_str = 40'("jal");
      7'b1100111: dec_str = f3_q == 3'b000 ? 40'("jalr") : '0;
      7'b1100011: case (f3_q)
        3'b000: dec_str = 40'("beq");
        3'b001: dec_str = 40'("bne");
        3'b100: dec_str = 40'("blt");
        3'b101: dec_str = 40'("bge");
        3'b110: dec_str = 40'("bltu");
        3'b111: dec_str = 40'("bgeu");
        default: ;
      endcase
      7'b0000011: case (f3_q)
        3'b000: dec_str = 40'("lb");
        3'b001: dec_str = 40'("lh");
        3'b010: dec_str = 40'("lw");
        3'b100: dec_str = 40'("lbu");
        3'b101: dec_str = 40'("lhu");
        default: ;
      endcase
      7'b0100011: case (f3_q)
        3'b000: dec_str = 40'("sb");
        3'b001: dec_str = 40'("sh");
        3'b010: dec_str = 40'("sw");
        default: ;
      endcase
      7'b0010011: case (f3_q)
        3'b000: dec_str = 40'("addi");
        3'b001: dec_str = f7_q == 7'h00 ? 40'("slli") : '0;
        3'b010: dec_str = 40'("slti");
        3'b011: dec_str = 40'("sltiu");
        3'b100: dec_str = 40'("xori");
        3'b101: dec_str = f7_q == 7'h00 ? 40'("srli") : f7_q == 7'h20 ? 40'("srai") : '0;
        3'b110: dec_str = 40'("ori");
        3'b111: dec_str = 40'("andi");
      endcase
      7'b0110011: case (f7_q)
        7'h00: case (f3_q)
          3'b000: dec_str = 40'("add");
          3'b001: dec_str = 40'("sll");
          3'b010: dec_str = 40'("slt");
          3'b011: dec_str = 40'("sltu");
          3'b100: dec_str = 40'("xor");
          3'b101: dec_str = 40'("srl");
          3'b110: dec_str = 40'("or");
          3'b111: dec_str = 40'("and");
        endcase
        7'h20: dec_str = f3_q == 3'b000 ? 40'("sub") : f3_q == 3'b101 ? 40'("sra") : '0;
        default: ;
      endcase
      default: ;
    endcase
    dec_len  = dec_str[39:32] != 8'h00 ? 3'd5 : dec_str[31:24] != 8'h00 ? 3'd4 :
               dec_str[23:16] != 8'h00 ? 3'd3 : 3'd2;
    dec_left = dec_str << (6'd8 * (6'd5 - {3'b000, dec_len}));
  end
  // buffer[39:32] always holds the character currently presented; it shifts up on each handshake
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      buffer  <= '0;
      len     <= '0;
      idx     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          op_q   <= io.opcode;
          f3_q   <= io.funct3;
          f7_q   <= io.funct7;
          busy_q <= 1'b1;
          state  <= LOOKUP;
        end
        LOOKUP: begin
          buffer <= dec_left;
          len    <= dec_len;
          idx    <= '0;
          if (dec_str != '0) begin
            out_q   <= dec_left[39:32];
            valid_q <= 1'b1;
            state   <= EMIT;
          end else begin
            error_q <= 1'b1;
            state   <= ERROR;
          end
        end
        EMIT: if (io.ascii_ready) begin
          idx    <= idx + 3'd1;
          buffer <= buffer << 8;
          out_q  <= idx == len - 3'd1 ? TERMINATOR : buffer[31:24];
          state  <= idx == len - 3'd1 ? TERM : EMIT;
        end
        TERM: if (io.ascii_ready) begin
          out_q   <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
          state   <= DONE;
        end
        default: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
  assign io.ascii_out   = out_q;
  assign io.ascii_valid = valid_q;
  assign io.busy_flag   = busy_q;
  assign io.done_flag   = done_q;
  assign io.error_flag  = error_q;
endmodule

// File: tb/tb_instruction_printer.sv
// tb_instruction_printer: scoreboard bench; stimulus queues expected bytes/flags, a monitor pops and compares
module tb_instruction_printer;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;
  instruction_printer_if io();
  instruction_printer #(.TERMINATOR(8'h20)) dut (.clk_in(clk_in), .rst_in(rst_in), .io(io));
  localparam logic [9:0] DONE_ITEM = 10'h100;
  localparam logic [9:0] ERR_ITEM  = 10'h200;
  logic [9:0] exp_q[$];
  int   checks = 0, failures = 0, hs_count = 0;
  bit   rnd = 1'b0, manual = 1'b0, prev_stall = 1'b0, prev_flag = 1'b0;
  logic [7:0] prev_byte = '0;
  task automatic expect_eq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic pop_check(string name, logic [9:0] act);
    logic [9:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got %h, expected nothing (queue empty)", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        failures++;
        $display("FAIL %s: got %h, expected %h", name, act, e);
      end
    end
  endtask
  initial forever begin
    @(negedge clk_in);
    if (io.ascii_valid && io.ascii_ready) begin
      hs_count++;
      pop_check("char", {2'b00, io.ascii_out});
    end
    if (prev_stall && io.ascii_valid) expect_eq("stall_hold", 32'(io.ascii_out), 32'(prev_byte));
    if (io.done_flag) pop_check("done", DONE_ITEM);
    if (io.error_flag) begin
      pop_check("error", ERR_ITEM);
      expect_eq("error_novalid", 32'(io.ascii_valid), 0);
    end
    if (io.done_flag || io.error_flag) expect_eq("flag_one_cycle", 32'(prev_flag), 0);
    prev_flag  = io.done_flag || io.error_flag;
    prev_stall = io.ascii_valid && !io.ascii_ready;
    prev_byte  = io.ascii_out;
  end
  initial forever begin
    @(posedge clk_in);
    #1;
    if (!manual) io.ascii_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  // kind: 0 normal mnemonic, 1 illegal encoding, 2 aborted by reset (no done expected)
  task automatic issue(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, string s, int kind);
    @(posedge clk_in);
    #1;
    io.start = 1'b1; io.opcode = op; io.funct3 = f3; io.funct7 = f7;
    if (kind == 1) exp_q.push_back(ERR_ITEM);
    else begin
      for (int i = 0; i < s.len(); i++) exp_q.push_back({2'b00, s.getc(i)});
      if (kind == 0) exp_q.push_back(DONE_ITEM);
    end
    @(posedge clk_in);
    #1;
    io.start = 1'b0;
  endtask
  task automatic wait_end(string name, int exp_cycle);
    int n = 0;
    do begin
      @(posedge clk_in);
      #1;
      n++;
    end while (!(io.done_flag || io.error_flag) && n < 200);
    expect_eq({name, "_end"}, 32'(io.done_flag || io.error_flag), 1);
    if (exp_cycle != 0) expect_eq({name, "_latency"}, n + 1, exp_cycle);
    @(posedge clk_in);
    #1;
    expect_eq({name, "_idle"}, 32'({io.busy_flag, io.done_flag, io.error_flag}), 0);
  endtask
  task automatic run(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, string s, int kind, int lat);
    issue(op, f3, f7, s, kind);
    wait_end(s, lat);
  endtask
  initial begin
    int base, n;
    io.start = 1'b0; io.opcode = '0; io.funct3 = '0; io.funct7 = '0; io.ascii_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    io.start = 1'b1; io.opcode = 7'b0110111;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0; io.start = 1'b0;
    expect_eq("reset_state", 32'({io.ascii_valid, io.ascii_out, io.busy_flag, io.done_flag, io.error_flag}), 0);
    @(posedge clk_in);
    #1;
    expect_eq("start_during_rst", 32'(io.busy_flag), 0);
    run(7'b0110011, 3'b000, 7'h20, "sub ", 0, 6);
    run(7'b0010111, 3'b000, 7'h00, "auipc ", 0, 8);
    run(7'b0000011, 3'b000, 7'h00, "lb ", 0, 5);
    run(7'b0010011, 3'b011, 7'h00, "sltiu ", 0, 8);
    manual = 1'b1; io.ascii_ready = 1'b1;
    issue(7'b0010011, 3'b101, 7'h20, "srai ", 0);
    base = hs_count;
    n = 0;
    do begin
      @(posedge clk_in);
      #1;
      n++;
    end while (!(io.ascii_valid && io.ascii_out == 8'h72) && n < 20);
    io.ascii_ready = 1'b0;
    expect_eq("srai_r_presented", 32'(io.ascii_out), 32'h72);
    repeat (3) @(posedge clk_in);
    #1;
    expect_eq("srai_r_stalled", 32'({io.ascii_valid, io.ascii_out}), 32'h172);
    io.ascii_ready = 1'b1; manual = 1'b0;
    wait_end("srai", 0);
    expect_eq("srai_handshakes", hs_count - base, 5);
    run(7'b1100011, 3'b010, 7'h00, "", 1, 2);
    run(7'b0110011, 3'b001, 7'h20, "", 1, 2);
    issue(7'b1100011, 3'b111, 7'h00, "bg", 2);
    base = hs_count;
    n = 0;
    while (hs_count < base + 2 && n < 50) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    manual = 1'b1; io.ascii_ready = 1'b0; rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    expect_eq("reset_mid_emit", 32'({io.ascii_valid, io.ascii_out, io.busy_flag, io.done_flag, io.error_flag}), 0);
    expect_eq("queue_after_rst", exp_q.size(), 0);
    io.ascii_ready = 1'b1; manual = 1'b0;
    run(7'b0110111, 3'b000, 7'h00, "lui ", 0, 6);
    @(posedge clk_in);
    #1;
    io.start = 1'b1; io.opcode = 7'b0110011; io.funct3 = 3'b000; io.funct7 = 7'h00;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({2'b00, 8'h61}); exp_q.push_back({2'b00, 8'h64});
      exp_q.push_back({2'b00, 8'h64}); exp_q.push_back({2'b00, 8'h20});
      exp_q.push_back(DONE_ITEM);
    end
    n = 0;
    do begin
      @(posedge clk_in);
      #1;
      n++;
    end while (!io.done_flag && n < 50);
    @(posedge clk_in);
    #1;
    expect_eq("held_gap_idle", 32'(io.busy_flag), 0);
    @(posedge clk_in);
    #1;
    expect_eq("held_relookup", 32'(io.busy_flag), 1);
    io.start = 1'b0;
    wait_end("held2", 0);
    rnd = 1'b1;
    run(7'b0110111, 3'b000, 7'h00, "lui ", 0, 0);
    run(7'b0010111, 3'b000, 7'h00, "auipc ", 0, 0);
    run(7'b1101111, 3'b000, 7'h00, "jal ", 0, 0);
    run(7'b1100111, 3'b000, 7'h00, "jalr ", 0, 0);
    run(7'b1100011, 3'b000, 7'h00, "beq ", 0, 0);
    run(7'b1100011, 3'b001, 7'h00, "bne ", 0, 0);
    run(7'b1100011, 3'b100, 7'h00, "blt ", 0, 0);
    run(7'b1100011, 3'b101, 7'h00, "bge ", 0, 0);
    run(7'b1100011, 3'b110, 7'h00, "bltu ", 0, 0);
    run(7'b1100011, 3'b111, 7'h00, "bgeu ", 0, 0);
    run(7'b0000011, 3'b000, 7'h00, "lb ", 0, 0);
    run(7'b0000011, 3'b001, 7'h00, "lh ", 0, 0);
    run(7'b0000011, 3'b010, 7'h00, "lw ", 0, 0);
    run(7'b0000011, 3'b100, 7'h00, "lbu ", 0, 0);
    run(7'b0000011, 3'b101, 7'h00, "lhu ", 0, 0);
    run(7'b0100011, 3'b000, 7'h00, "sb ", 0, 0);
    run(7'b0100011, 3'b001, 7'h00, "sh ", 0, 0);
    run(7'b0100011, 3'b010, 7'h00, "sw ", 0, 0);
    run(7'b0010011, 3'b000, 7'h55, "addi ", 0, 0);
    run(7'b0010011, 3'b010, 7'h55, "slti ", 0, 0);
    run(7'b0010011, 3'b011, 7'h55, "sltiu ", 0, 0);
    run(7'b0010011, 3'b100, 7'h55, "xori ", 0, 0);
    run(7'b0010011, 3'b110, 7'h55, "ori ", 0, 0);
    run(7'b0010011, 3'b111, 7'h55, "andi ", 0, 0);
    run(7'b0010011, 3'b001, 7'h00, "slli ", 0, 0);
    run(7'b0010011, 3'b101, 7'h00, "srli ", 0, 0);
    run(7'b0010011, 3'b101, 7'h20, "srai ", 0, 0);
    run(7'b0110011, 3'b000, 7'h00, "add ", 0, 0);
    run(7'b0110011, 3'b001, 7'h00, "sll ", 0, 0);
    run(7'b0110011, 3'b010, 7'h00, "slt ", 0, 0);
    run(7'b0110011, 3'b011, 7'h00, "sltu ", 0, 0);
    run(7'b0110011, 3'b100, 7'h00, "xor ", 0, 0);
    run(7'b0110011, 3'b101, 7'h00, "srl ", 0, 0);
    run(7'b0110011, 3'b110, 7'h00, "or ", 0, 0);
    run(7'b0110011, 3'b111, 7'h00, "and ", 0, 0);
    run(7'b0110011, 3'b000, 7'h20, "sub ", 0, 0);
    run(7'b0110011, 3'b101, 7'h20, "sra ", 0, 0);
    rnd = 1'b0;
    run(7'b0010011, 3'b001, 7'h20, "", 1, 0);
    run(7'b1100111, 3'b001, 7'h00, "", 1, 0);
    @(posedge clk_in);
    #1;
    expect_eq("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
